// File: rtl/dmem_responder_if.sv
// Load/store bus between the MEM stage and the data-memory responder.
// master = pipeline (requests), slave = responder (data, stall, misalign).
interface dmem_responder_if;
  logic        memreadm;
  logic        memwritem;
  logic [31:0] aluoutm;
  logic [31:0] writedatam;
  logic [31:0] readdatam;
  logic        stallm;
  logic        misalignm;

  modport master (
    output memreadm,
    output memwritem,
    output aluoutm,
    output writedatam,
    input  readdatam,
    input  stallm,
    input  misalignm
  );

  modport slave (
    input  memreadm,
    input  memwritem,
    input  aluoutm,
    input  writedatam,
    output readdatam,
    output stallm,
    output misalignm
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory for the MEM stage with LATENCY stall cycles.
// Ports: clk, reset (async, active low), bus (slave modport of
// dmem_responder_if); rdcount/wrcount exist with DMEM_ACCESS_CNT_EN.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_responder_if.slave      bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [CNTW-1:0]      rdcount,
  output logic [CNTW-1:0]      wrcount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [31:0]   RAM [DEPTH];

  logic [1:0]    state, state_n;
  logic [LW-1:0] cnt, cnt_n;
  logic [AW-1:0] cap_idx;
  logic [31:0]   cap_wd;
  logic          cap_wr;
  logic [31:0]   rdata_q;

  logic [AW-1:0] idx;
  logic          req;
  logic          bad;
  logic          in_idle;
  logic          misal_hit;
  logic          take;

  // fin marks the edge that completes an access
  logic          fin;
  logic [AW-1:0] fin_idx;
  logic [31:0]   fin_wd;
  logic          fin_wr;

`ifdef DMEM_ACCESS_CNT_EN
  logic          cap_rd;
  logic          fin_rd;
`endif

  logic          unused_hi;
  assign unused_hi = ^bus.aluoutm[31:AW+2];

  assign idx       = bus.aluoutm[AW+1:2];
  assign req       = bus.memreadm | bus.memwritem;
  assign bad       = |bus.aluoutm[1:0];
  assign in_idle   = (state == S_IDLE);
  assign misal_hit = in_idle && req && bad;
  assign take      = in_idle && req && !bad;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fin     = 1'b0;
    fin_idx = cap_idx;
    fin_wd  = cap_wd;
    fin_wr  = cap_wr;
`ifdef DMEM_ACCESS_CNT_EN
    fin_rd  = cap_rd;
`endif
    if (LATENCY == 0) begin
      fin     = take;
      fin_idx = idx;
      fin_wd  = bus.writedatam;
      fin_wr  = bus.memwritem;
`ifdef DMEM_ACCESS_CNT_EN
      fin_rd  = bus.memreadm;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) begin
            cnt_n = LW'(LATENCY - 1);
            if (LATENCY == 1) begin
              // single stall cycle: complete straight from live inputs
              state_n = S_DONE;
              fin     = 1'b1;
              fin_idx = idx;
              fin_wd  = bus.writedatam;
              fin_wr  = bus.memwritem;
`ifdef DMEM_ACCESS_CNT_EN
              fin_rd  = bus.memreadm;
`endif
            end else begin
              state_n = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_n = cnt - LW'(1);
          if (cnt == LW'(1)) begin
            state_n = S_DONE;
            fin     = 1'b1;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cap_idx <= '0;
      cap_wd  <= '0;
      cap_wr  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) begin
        cap_idx <= idx;
        cap_wd  <= bus.writedatam;
        cap_wr  <= bus.memwritem;
      end
      if (fin)
        rdata_q <= RAM[fin_idx];
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_rd  <= 1'b0;
      rdcount <= '0;
      wrcount <= '0;
    end else begin
      if (take)
        cap_rd <= bus.memreadm;
      if (fin && fin_rd && !(&rdcount))
        rdcount <= rdcount + CNTW'(1);
      if (fin && fin_wr && !(&wrcount))
        wrcount <= wrcount + CNTW'(1);
    end
  end
`endif

  // RAM is never cleared; a store pending at reset is simply dropped
  always_ff @(posedge clk) begin
    if (reset && fin && fin_wr)
      RAM[fin_idx] <= fin_wd;
  end

  always_comb begin
    if (!reset || misal_hit)
      bus.readdatam = '0;
    else if (LATENCY == 0)
      bus.readdatam = RAM[idx];
    else
      bus.readdatam = rdata_q;
  end

  assign bus.stallm    = reset && (LATENCY != 0) &&
                         (take || state == S_WAIT);
  assign bus.misalignm = reset && misal_hit;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at several latencies.
// Expected values are hand-computed constants.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  dmem_responder_if b2 ();
  dmem_responder_if b0 ();
  dmem_responder_if b3 ();
  dmem_responder_if b4 ();

`ifdef DMEM_ACCESS_CNT_EN
  dmem_responder_if bc ();
  logic [15:0] rc2, wc2, rc0, wc0, rc3, wc3, rc4, wc4;
  logic [1:0]  rcc, wcc;
`endif

  dmem_responder #(.DEPTH(128), .LATENCY(2)) datamem (
    .clk(clk), .reset(reset), .bus(b2)
`ifdef DMEM_ACCESS_CNT_EN
    , .rdcount(rc2), .wrcount(wc2)
`endif
  );

  dmem_responder #(.DEPTH(128), .LATENCY(0)) d0 (
    .clk(clk), .reset(reset), .bus(b0)
`ifdef DMEM_ACCESS_CNT_EN
    , .rdcount(rc0), .wrcount(wc0)
`endif
  );

  dmem_responder #(.DEPTH(128), .LATENCY(3)) d3 (
    .clk(clk), .reset(reset), .bus(b3)
`ifdef DMEM_ACCESS_CNT_EN
    , .rdcount(rc3), .wrcount(wc3)
`endif
  );

  dmem_responder #(.DEPTH(128), .LATENCY(4)) d4 (
    .clk(clk), .reset(reset), .bus(b4)
`ifdef DMEM_ACCESS_CNT_EN
    , .rdcount(rc4), .wrcount(wc4)
`endif
  );

`ifdef DMEM_ACCESS_CNT_EN
  dmem_responder #(.DEPTH(128), .LATENCY(1), .CNTW(2)) dc (
    .clk(clk), .reset(reset), .bus(bc),
    .rdcount(rcc), .wrcount(wcc)
  );
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    {b2.memreadm, b2.memwritem} = 2'b00;
    {b0.memreadm, b0.memwritem} = 2'b00;
    {b3.memreadm, b3.memwritem} = 2'b00;
    {b4.memreadm, b4.memwritem} = 2'b00;
    b2.aluoutm = 0; b2.writedatam = 0;
    b0.aluoutm = 0; b0.writedatam = 0;
    b3.aluoutm = 0; b3.writedatam = 0;
    b4.aluoutm = 0; b4.writedatam = 0;
`ifdef DMEM_ACCESS_CNT_EN
    {bc.memreadm, bc.memwritem} = 2'b00;
    bc.aluoutm = 0; bc.writedatam = 0;
`endif
    repeat (3) step();
    chk("rst_stall", 32'(b2.stallm), 32'd0);
    chk("rst_rdata", b2.readdatam, 32'd0);
    chk("rst_misal", 32'(b2.misalignm), 32'd0);
    reset = 1'b1;

    // LATENCY=2 store then load
    step();
    b2.memwritem = 1'b1;
    b2.aluoutm = 32'h80;
    b2.writedatam = 32'hDEADBEEF;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (b2.stallm !== 1'b1) break;
      n++;
      step(); #1;
    end
    chk("l2_st_stalls", 32'(n), 32'd2);
    b2.memwritem = 1'b0;
    step();
    chk("l2_ram", datamem.RAM[32], 32'hDEADBEEF);
    b2.memreadm = 1'b1;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (b2.stallm !== 1'b1) break;
      n++;
      step(); #1;
    end
    chk("l2_ld_stalls", 32'(n), 32'd2);
    chk("l2_ld_data", b2.readdatam, 32'hDEADBEEF);
    b2.memreadm = 1'b0;
    step();
    chk("l2_hold", b2.readdatam, 32'hDEADBEEF);
    chk("l2_idle_stall", 32'(b2.stallm), 32'd0);

    // LATENCY=0 alternating store/load
    b0.memwritem = 1'b1;
    b0.aluoutm = 32'h04;
    b0.writedatam = 32'h11111111;
    #1;
    chk("l0_st_stall", 32'(b0.stallm), 32'd0);
    step();
    b0.memwritem = 1'b0;
    b0.memreadm = 1'b1;
    #1;
    chk("l0_ld_stall", 32'(b0.stallm), 32'd0);
    chk("l0_ld_data", b0.readdatam, 32'h11111111);
    step();
    b0.memwritem = 1'b1;
    b0.writedatam = 32'h22222222;
    #1;
    chk("l0_rbw_old", b0.readdatam, 32'h11111111);
    step();
    b0.memwritem = 1'b0;
    #1;
    chk("l0_rbw_new", b0.readdatam, 32'h22222222);
    b0.memreadm = 1'b0;

    // LATENCY=3 address wrap
    step();
    b3.memwritem = 1'b1;
    b3.aluoutm = 32'h204;
    b3.writedatam = 32'h5A5A5A5A;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (b3.stallm !== 1'b1) break;
      n++;
      step(); #1;
    end
    chk("l3_st_stalls", 32'(n), 32'd3);
    b3.memwritem = 1'b0;
    step();
    b3.memreadm = 1'b1;
    b3.aluoutm = 32'h004;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (b3.stallm !== 1'b1) break;
      n++;
      step(); #1;
    end
    chk("l3_ld_stalls", 32'(n), 32'd3);
    chk("l3_wrap_data", b3.readdatam, 32'h5A5A5A5A);
    chk("l3_ram1", d3.RAM[1], 32'h5A5A5A5A);
    b3.memreadm = 1'b0;

    // misaligned load on LATENCY=2
    step();
    b2.memreadm = 1'b1;
    b2.aluoutm = 32'h83;
    #1;
    chk("mis_pulse", 32'(b2.misalignm), 32'd1);
    chk("mis_stall", 32'(b2.stallm), 32'd0);
    chk("mis_rdata", b2.readdatam, 32'd0);
    b2.memreadm = 1'b0;
    step();
    chk("mis_clear", 32'(b2.misalignm), 32'd0);
    chk("mis_hold", b2.readdatam, 32'hDEADBEEF);
    chk("mis_ram", datamem.RAM[32], 32'hDEADBEEF);
`ifdef DMEM_ACCESS_CNT_EN
    chk("mis_rdcount", 32'(rc2), 32'd1);
`endif

    // LATENCY=4 reset in the middle of WAIT
    b4.memwritem = 1'b1;
    b4.aluoutm = 32'h10;
    b4.writedatam = 32'hCAFEF00D;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (b4.stallm !== 1'b1) break;
      n++;
      step(); #1;
    end
    chk("l4_st_stalls", 32'(n), 32'd4);
    b4.memwritem = 1'b0;
    step();
    b4.memwritem = 1'b1;
    b4.writedatam = 32'h12345678;
    #1;
    step();
    step();
    chk("l4_wait2_stall", 32'(b4.stallm), 32'd1);
    reset = 1'b0;
    #1;
    chk("l4_rst_stall", 32'(b4.stallm), 32'd0);
    chk("l4_rst_rdata", b4.readdatam, 32'd0);
    b4.memwritem = 1'b0;
    step();
    reset = 1'b1;
    step();
    b4.memreadm = 1'b1;
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (b4.stallm !== 1'b1) break;
      n++;
      step(); #1;
    end
    chk("l4_ld_stalls", 32'(n), 32'd4);
    chk("l4_ld_old", b4.readdatam, 32'hCAFEF00D);
    chk("l4_ram", d4.RAM[4], 32'hCAFEF00D);
    b4.memreadm = 1'b0;

`ifdef DMEM_ACCESS_CNT_EN
    // saturating counters, CNTW=2, LATENCY=1
    step();
    chk("cnt_rst_rd", 32'(rcc), 32'd0);
    chk("cnt_rst_wr", 32'(wcc), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bc.memwritem = 1'b1;
      bc.aluoutm = 32'(i * 4);
      bc.writedatam = 32'(i);
      step();
      bc.memwritem = 1'b0;
      step();
    end
    chk("cnt_wr_sat", 32'(wcc), 32'd3);
    chk("cnt_rd_zero", 32'(rcc), 32'd0);
    {bc.memreadm, bc.memwritem} = 2'b11;
    bc.aluoutm = 32'h40;
    step();
    {bc.memreadm, bc.memwritem} = 2'b00;
    step();
    chk("cnt_wr_final", 32'(wcc), 32'd3);
    chk("cnt_rd_final", 32'(rcc), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
